// File: rtl/vx_scalar_operand_arb_pkg.sv
// Shared types for the scalar operand arbiter.
// Scalar operand bundle layout and width helpers.
package vx_scalar_operand_arb_pkg;

  localparam int XLEN        = 32;
  localparam int NUM_THREADS = 4;
  localparam int NUM_WARPS   = 4;
  localparam int UUID_W      = 44;
  localparam int NR_BITS     = 5;

  typedef struct packed {
    logic [UUID_W-1:0]                uuid;
    logic [$clog2(NUM_WARPS)-1:0]     wis;
    logic [NUM_THREADS-1:0]           tmask;
    logic [XLEN-1:0]                  pc;
    logic [1:0]                       ex_type;
    logic [3:0]                       op_type;
    logic [XLEN-1:0]                  imm;
    logic [NR_BITS-1:0]               rd;
    logic [NUM_THREADS-1:0][XLEN-1:0] rs1_data;
    logic [NUM_THREADS-1:0][XLEN-1:0] rs2_data;
    logic [NUM_THREADS-1:0][XLEN-1:0] rs3_data;
    logic                             is_branch;
  } data_t;

  localparam int SCALAR_DATAW = $bits(data_t);

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_scalar_operand_arb_skid_buf.sv
// Two-entry head/skid elastic buffer.
// Head always drives the output; skid absorbs one extra push.
module vx_scalar_skid_buf
  import vx_scalar_operand_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic             full,
  output logic [WIDTH-1:0] head_data
);

  buf_state_e state_q;
  buf_state_e state_d;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] skid_q;
  logic load_head;
  logic shift_skid;
  logic load_skid;

  // occupancy register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BUF_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // next occupancy and entry moves
  always_comb begin
    state_d    = state_q;
    load_head  = 1'b0;
    shift_skid = 1'b0;
    load_skid  = 1'b0;
    unique case (state_q)
      BUF_EMPTY: begin
        if (push) begin
          state_d   = BUF_ONE;
          load_head = 1'b1;
        end
      end
      BUF_ONE: begin
        if (push && pop) begin
          load_head = 1'b1;
        end else if (push) begin
          state_d   = BUF_TWO;
          load_skid = 1'b1;
        end else if (pop) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        if (pop) begin
          state_d    = BUF_ONE;
          shift_skid = 1'b1;
        end
      end
      default: begin
        state_d = BUF_EMPTY;
      end
    endcase
  end

  // payload storage, no reset needed
  always_ff @(posedge clk) begin
    if (load_head) begin
      head_q <= push_data;
    end else if (shift_skid) begin
      head_q <= skid_q;
    end
    if (load_skid) begin
      skid_q <= push_data;
    end
  end

  assign valid     = (state_q != BUF_EMPTY);
  assign full      = (state_q == BUF_TWO);
  assign head_data = head_q;

endmodule

// File: rtl/vx_scalar_operand_arb.sv
// Round-robin arbiter of operand bundles onto one scalar port.
// Optional perf counters: define VX_SCALAR_ARB_PERF_EN.
module vx_scalar_operand_arb
  import vx_scalar_operand_arb_pkg::*;
#(
  parameter int NUM_REQS   = 4,
  parameter int DATAW      = 64,
  parameter int SEL_W      = log2up(NUM_REQS),
  parameter int PERF_CTR_W = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       in_valid,
  input  logic [NUM_REQS*DATAW-1:0] in_data,
  output logic [NUM_REQS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [DATAW-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  input  logic                      out_ready
`ifdef VX_SCALAR_ARB_PERF_EN
  ,
  output logic [PERF_CTR_W-1:0]     perf_stall_cycles,
  output logic [PERF_CTR_W-1:0]     perf_conflict_cycles
`endif
);

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [DATAW-1:0] data;
  } entry_t;

  if (PERF_CTR_W < 1) begin : g_bad_ctr_w
    $error("PERF_CTR_W must be at least 1");
  end

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] winner;
  logic [DATAW-1:0] win_data;
  logic             any_valid;
  logic             buf_full;
  logic             buf_valid;
  logic             grant_ok;
  logic             push;
  logic             pop;
  entry_t           push_entry;
  entry_t           head_entry;

  assign any_valid = |in_valid;
  assign grant_ok  = !reset && any_valid && !buf_full;
  assign push      = grant_ok;
  assign out_valid = buf_valid && !reset;
  assign pop       = out_valid && out_ready;

  // first valid requester at or after rr_ptr
  always_comb begin
    int idx;
    logic found;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQS;
      if (!found && in_valid[idx]) begin
        winner = SEL_W'(idx);
        found  = 1'b1;
      end
    end
  end

  // one-hot ready and winner payload mux
  always_comb begin
    in_ready = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (winner == SEL_W'(i)) begin
        in_ready[i] = grant_ok;
        win_data    = in_data[i*DATAW +: DATAW];
      end
    end
  end

  // advance pointer past the winner on accept
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (push) begin
      if (winner == SEL_W'(NUM_REQS - 1)) begin
        rr_ptr <= '0;
      end else begin
        rr_ptr <= winner + SEL_W'(1);
      end
    end
  end

  assign push_entry.sel  = winner;
  assign push_entry.data = win_data;

  vx_scalar_skid_buf #(
    .WIDTH ($bits(entry_t))
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .valid     (buf_valid),
    .full      (buf_full),
    .head_data (head_entry)
  );

  assign out_data = head_entry.data;
  assign out_sel  = head_entry.sel;

`ifdef VX_SCALAR_ARB_PERF_EN
  logic multi_valid;
  assign multi_valid = |(in_valid & (in_valid - NUM_REQS'(1)));

  // stall and conflict cycle counters, wrap naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cycles    <= '0;
      perf_conflict_cycles <= '0;
    end else begin
      if (any_valid && buf_full) begin
        perf_stall_cycles <= perf_stall_cycles + PERF_CTR_W'(1);
      end
      if (multi_valid) begin
        perf_conflict_cycles <= perf_conflict_cycles + PERF_CTR_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_vx_scalar_operand_arb.sv
// Bench for vx_scalar_operand_arb.
// Cycle table plus ordered scoreboard on the output stream.
module tb_vx_scalar_operand_arb;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int SW = 2;
  localparam int NV = 34;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_sel;
  logic            out_ready;
`ifdef VX_SCALAR_ARB_PERF_EN
  logic [31:0]     perf_stall_cycles;
  logic [31:0]     perf_conflict_cycles;
`endif

  always #5 clk = ~clk;

  vx_scalar_operand_arb #(
    .NUM_REQS   (N),
    .DATAW      (DW),
    .SEL_W      (SW),
    .PERF_CTR_W (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
`ifdef VX_SCALAR_ARB_PERF_EN
    ,
    .perf_stall_cycles    (perf_stall_cycles),
    .perf_conflict_cycles (perf_conflict_cycles)
`endif
  );

  typedef struct packed {
    logic          rst;
    logic [N-1:0]  v;
    logic          r;
    logic [N-1:0]  rdy;
    logic          ov;
    logic [SW-1:0] sel;
  } vec_t;

  typedef struct packed {
    logic [SW-1:0] sel;
    logic [DW-1:0] data;
  } exp_t;

  vec_t        vecs[NV];
  exp_t        sb[$];
  logic [31:0] seq[N];
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic vec_t mkv(input logic rst, input logic [3:0] v,
                               input logic r, input logic [3:0] rdy,
                               input logic ov, input logic [1:0] sel);
    vec_t e;
    e.rst = rst;
    e.v   = v;
    e.r   = r;
    e.rdy = rdy;
    e.ov  = ov;
    e.sel = sel;
    return e;
  endfunction

  function automatic logic [DW-1:0] req_data(input int i, input logic [31:0] s);
    return {32'(i + 1), s};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [N-1:0] acc;
    exp_t e;
    // reset
    vecs[0]  = mkv(1, 4'b0000, 1, 4'b0000, 0, 0);
    vecs[1]  = mkv(1, 4'b1111, 1, 4'b0000, 0, 0);
    vecs[2]  = mkv(0, 4'b0000, 1, 4'b0000, 0, 0);
    // all requesting, full throughput
    vecs[3]  = mkv(0, 4'b1111, 1, 4'b0001, 0, 0);
    vecs[4]  = mkv(0, 4'b1111, 1, 4'b0010, 1, 0);
    vecs[5]  = mkv(0, 4'b1111, 1, 4'b0100, 1, 1);
    vecs[6]  = mkv(0, 4'b1111, 1, 4'b1000, 1, 2);
    vecs[7]  = mkv(0, 4'b1111, 1, 4'b0001, 1, 3);
    vecs[8]  = mkv(0, 4'b1111, 1, 4'b0010, 1, 0);
    vecs[9]  = mkv(0, 4'b1111, 1, 4'b0100, 1, 1);
    vecs[10] = mkv(0, 4'b1111, 1, 4'b1000, 1, 2);
    vecs[11] = mkv(0, 4'b0000, 1, 4'b0000, 1, 3);
    vecs[12] = mkv(0, 4'b0000, 1, 4'b0000, 0, 0);
    // sparse requesters 1 and 3
    vecs[13] = mkv(0, 4'b1010, 1, 4'b0010, 0, 0);
    vecs[14] = mkv(0, 4'b1010, 1, 4'b1000, 1, 1);
    vecs[15] = mkv(0, 4'b1010, 1, 4'b0010, 1, 3);
    vecs[16] = mkv(0, 4'b1010, 1, 4'b1000, 1, 1);
    vecs[17] = mkv(0, 4'b0000, 1, 4'b0000, 1, 3);
    vecs[18] = mkv(0, 4'b0000, 1, 4'b0000, 0, 0);
    // backpressure fills both entries then drains
    vecs[19] = mkv(0, 4'b1111, 0, 4'b0001, 0, 0);
    vecs[20] = mkv(0, 4'b1111, 0, 4'b0010, 1, 0);
    vecs[21] = mkv(0, 4'b1111, 0, 4'b0000, 1, 0);
    vecs[22] = mkv(0, 4'b1111, 0, 4'b0000, 1, 0);
    vecs[23] = mkv(0, 4'b1111, 0, 4'b0000, 1, 0);
    vecs[24] = mkv(0, 4'b1111, 1, 4'b0000, 1, 0);
    vecs[25] = mkv(0, 4'b1111, 1, 4'b0100, 1, 1);
    vecs[26] = mkv(0, 4'b0000, 1, 4'b0000, 1, 2);
    vecs[27] = mkv(0, 4'b0000, 1, 4'b0000, 0, 0);
    // reset while full
    vecs[28] = mkv(0, 4'b1111, 0, 4'b1000, 0, 0);
    vecs[29] = mkv(0, 4'b1111, 0, 4'b0001, 1, 3);
    vecs[30] = mkv(1, 4'b1111, 1, 4'b0000, 0, 0);
    vecs[31] = mkv(0, 4'b1111, 1, 4'b0001, 0, 0);
    vecs[32] = mkv(0, 4'b0000, 1, 4'b0000, 1, 0);
    vecs[33] = mkv(0, 4'b0000, 1, 4'b0000, 0, 0);

    for (int i = 0; i < N; i++) seq[i] = 32'h100 * (i + 1);
    reset     = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;

    for (int t = 0; t < NV; t++) begin
      @(negedge clk);
      reset     = vecs[t].rst;
      in_valid  = vecs[t].v;
      out_ready = vecs[t].r;
      for (int i = 0; i < N; i++) in_data[i*DW +: DW] = req_data(i, seq[i]);
      #1;
      chk($sformatf("in_ready@%0d", t), DW'(in_ready), DW'(vecs[t].rdy));
      chk($sformatf("out_valid@%0d", t), DW'(out_valid), DW'(vecs[t].ov));
      if (vecs[t].ov)
        chk($sformatf("out_sel@%0d", t), DW'(out_sel), DW'(vecs[t].sel));
      if (vecs[t].rst) begin
        sb.delete();
      end else begin
        if (out_valid) begin
          if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_empty@%0d: got out_valid=1 expected no bundle", t);
          end else begin
            e = sb[0];
            chk($sformatf("sb_data@%0d", t), out_data, e.data);
            chk($sformatf("sb_sel@%0d", t), DW'(out_sel), DW'(e.sel));
            if (out_ready) void'(sb.pop_front());
          end
        end
        for (int i = 0; i < N; i++) begin
          if (vecs[t].rdy[i]) begin
            e.sel  = SW'(i);
            e.data = req_data(i, seq[i]);
            sb.push_back(e);
          end
        end
      end
`ifdef VX_SCALAR_ARB_PERF_EN
      if (t == 27) begin
        chk("perf_stall", DW'(perf_stall_cycles), DW'(4));
        chk("perf_conflict", DW'(perf_conflict_cycles), DW'(19));
      end
`endif
      acc = in_valid & in_ready;
      for (int i = 0; i < N; i++) if (acc[i]) seq[i] = seq[i] + 1;
    end

    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d entries expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
